// File: rtl/object_memory_arbiter_pkg.sv
// Shared defaults and state encoding for the object memory arbiter and its RAM.
package object_memory_arbiter_pkg;
   localparam int ADDR_W_DEF        = 7;
   localparam int DATA_W_DEF        = 11;
   localparam int BOARD_WORDS_DEF   = 104;
   localparam int GRANT_TIMEOUT_DEF = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      LOADING = 2'd2,
      PLAYING = 2'd3
   } arb_state_t;
endpackage

// File: rtl/object_memory_arbiter_object_memory.sv
// Simple dual-port RAM: one synchronous write port, registered read-before-write port.
module object_memory
   import object_memory_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);
   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Contents survive reset; only the read register is cleared.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_data <= '0;
      else        rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/object_memory_arbiter.sv
// Hands the object memory write port to the new-game coordinator or the engine by state.
// All outputs registered; state outputs follow the sampling edge, reads have 1-cycle latency.
module object_memory_arbiter
   import object_memory_arbiter_pkg::*;
#(
   parameter int ADDR_W        = ADDR_W_DEF,
   parameter int DATA_W        = DATA_W_DEF,
   parameter int BOARD_WORDS   = BOARD_WORDS_DEF,
   parameter int GRANT_TIMEOUT = GRANT_TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              new_game_request,
   output logic              new_game_in_progress,
   input  logic              resetting,
   input  logic              new_game_ready,
   input  logic [ADDR_W-1:0] ngc_addr,
   input  logic [DATA_W-1:0] ngc_data,
   input  logic              ngc_wren,
   input  logic [ADDR_W-1:0] eng_addr,
   input  logic [DATA_W-1:0] eng_data,
   input  logic              eng_wren,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              game_active,
   output logic              load_error
);
   localparam int TO_W = $clog2(GRANT_TIMEOUT);
   localparam logic [TO_W-1:0]   TO_LAST = TO_W'(GRANT_TIMEOUT - 1);
   localparam logic [ADDR_W:0]   BW_EXT  = (ADDR_W + 1)'(BOARD_WORDS);

   arb_state_t        state_q, state_d;
   logic [TO_W-1:0]   tcnt_q, tcnt_d;
   logic [ADDR_W-1:0] lcnt_q, lcnt_d;
   logic              err_d;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   always_comb begin
      state_d = state_q;
      tcnt_d  = tcnt_q;
      lcnt_d  = lcnt_q;
      err_d   = 1'b0;
      wr_en   = 1'b0;
      wr_addr = ngc_addr;
      wr_data = ngc_data;
      case (state_q)
         IDLE: begin
            if (new_game_request) begin
               state_d = GRANT;
               tcnt_d  = '0;
            end
         end
         GRANT: begin
            if (resetting) begin
               state_d = LOADING;
               lcnt_d  = '0;
            end else if (tcnt_q == TO_LAST) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else begin
               tcnt_d = tcnt_q + TO_W'(1);
            end
         end
         LOADING: begin
            wr_en = ngc_wren;
            // Only in-board writes count, and the count saturates at a full board.
            if (ngc_wren && ({1'b0, ngc_addr} < BW_EXT) && ({1'b0, lcnt_q} < BW_EXT))
               lcnt_d = lcnt_q + ADDR_W'(1);
            if (new_game_ready) begin
               state_d = PLAYING;
               err_d   = ({1'b0, lcnt_q} < BW_EXT);
            end else if (!resetting) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end
         end
         PLAYING: begin
            wr_en   = eng_wren;
            wr_addr = eng_addr;
            wr_data = eng_data;
            if (new_game_request) begin
               state_d = GRANT;
               tcnt_d  = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q              <= IDLE;
         tcnt_q               <= '0;
         lcnt_q               <= '0;
         new_game_in_progress <= 1'b0;
         game_active          <= 1'b0;
         load_error           <= 1'b0;
      end else begin
         state_q              <= state_d;
         tcnt_q               <= tcnt_d;
         lcnt_q               <= lcnt_d;
         new_game_in_progress <= (state_d == GRANT) || (state_d == LOADING);
         game_active          <= (state_d == PLAYING);
         load_error           <= err_d;
      end
   end

   object_memory #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mem (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );
endmodule

// File: tb/tb_object_memory_arbiter.sv
// Scoreboard bench: a cycle-level reference model queues expected outputs, a negedge monitor checks them.
module tb_object_memory_arbiter;
   localparam int AW = 7;
   localparam int DW = 11;
   localparam int BW = 104;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req, nip, resetting, ready;
   logic [AW-1:0] ngc_addr, eng_addr, rd_addr;
   logic [DW-1:0] ngc_data, eng_data, rd_data;
   logic          ngc_wren, eng_wren, game_active, load_error;

   object_memory_arbiter dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .new_game_request     (req),
      .new_game_in_progress (nip),
      .resetting            (resetting),
      .new_game_ready       (ready),
      .ngc_addr             (ngc_addr),
      .ngc_data             (ngc_data),
      .ngc_wren             (ngc_wren),
      .eng_addr             (eng_addr),
      .eng_data             (eng_data),
      .eng_wren             (eng_wren),
      .rd_addr              (rd_addr),
      .rd_data              (rd_data),
      .game_active          (game_active),
      .load_error           (load_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          nip;
      logic          ga;
      logic          le;
      logic          rd_known;
      logic [DW-1:0] rd;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
      checks++;
      if (act !== req_v) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req_v, $time);
      end
   endtask

   // Reference model: phase of the game, board word bookkeeping and a shadow memory.
   typedef enum {M_IDLE, M_GRANT, M_LOAD, M_PLAY} mphase_t;
   mphase_t       ph = M_IDLE;
   int            cyc = 0;
   int            grant_cyc = 0;
   int            counted = 0;
   logic [DW-1:0] mmem [128];
   bit            known [128];

   task automatic model_step();
      exp_t    e;
      mphase_t cur;
      cyc++;
      if (!rst_n) begin
         ph = M_IDLE;
         e  = '{nip: 1'b0, ga: 1'b0, le: 1'b0, rd_known: 1'b1, rd: '0};
         sbq.push_back(e);
         return;
      end
      cur        = ph;
      e.le       = 1'b0;
      e.rd_known = known[rd_addr];
      e.rd       = mmem[rd_addr];
      case (cur)
         M_IDLE: if (req) begin ph = M_GRANT; grant_cyc = cyc; end
         M_GRANT: begin
            if (resetting) begin ph = M_LOAD; counted = 0; end
            else if (cyc - grant_cyc == TO) begin ph = M_IDLE; e.le = 1'b1; end
         end
         M_LOAD: begin
            if (ready) begin ph = M_PLAY; e.le = (counted < BW); end
            else if (!resetting) begin ph = M_IDLE; e.le = 1'b1; end
            if (ngc_wren) begin
               mmem[ngc_addr]  = ngc_data;
               known[ngc_addr] = 1'b1;
               if (int'(ngc_addr) < BW && counted < BW) counted++;
            end
         end
         M_PLAY: begin
            if (eng_wren) begin
               mmem[eng_addr]  = eng_data;
               known[eng_addr] = 1'b1;
            end
            if (req) begin ph = M_GRANT; grant_cyc = cyc; end
         end
         default: ph = M_IDLE;
      endcase
      e.nip = (ph == M_GRANT) || (ph == M_LOAD);
      e.ga  = (ph == M_PLAY);
      sbq.push_back(e);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk("new_game_in_progress", {31'd0, nip}, {31'd0, e.nip});
         chk("game_active", {31'd0, game_active}, {31'd0, e.ga});
         chk("load_error", {31'd0, load_error}, {31'd0, e.le});
         if (e.rd_known) chk("rd_data", {21'd0, rd_data}, {21'd0, e.rd});
      end
   end

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic quiet(input bit ngc_noise, input bit eng_noise);
      req      = 1'b0;
      ready    = 1'b0;
      rd_addr  = AW'($urandom_range(127));
      ngc_wren = ngc_noise ? 1'($urandom_range(1)) : 1'b0;
      ngc_addr = AW'($urandom_range(127));
      ngc_data = DW'($urandom_range(2047));
      eng_wren = eng_noise ? 1'($urandom_range(1)) : 1'b0;
      eng_addr = AW'($urandom_range(127));
      eng_data = DW'($urandom_range(2047));
   endtask

   task automatic start_load();
      quiet(1, 1); req = 1'b1; tick();
      quiet(1, 1); tick();
      quiet(1, 1); tick();
      quiet(0, 1); resetting = 1'b1; tick();
   endtask

   task automatic write_words(input int n);
      for (int i = 0; i < n; i++) begin
         quiet(0, 1);
         ngc_wren = 1'b1; ngc_addr = AW'(i); ngc_data = DW'(i);
         tick();
      end
   endtask

   // Engine write during LOADING must be dropped; then finish with the ready pulse.
   task automatic finish_load();
      quiet(0, 0); eng_wren = 1'b1; eng_addr = 7'd5; eng_data = 11'h7FF; rd_addr = 7'd5; tick();
      quiet(0, 0); rd_addr = 7'd5; tick();
      quiet(0, 1); ready = 1'b1; tick();
      quiet(1, 0); resetting = 1'b0; tick();
   endtask

   initial begin
      rst_n = 1'b0; resetting = 1'b0;
      quiet(0, 0);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (3) begin quiet(1, 1); tick(); end

      // full load of 0..104, then reads
      start_load(); write_words(105); finish_load();
      quiet(1, 0); rd_addr = 7'd57;  tick();
      quiet(1, 0); rd_addr = 7'd104; tick();
      // engine owns the port in PLAYING
      quiet(1, 0); eng_wren = 1'b1; eng_addr = 7'd5; eng_data = 11'h7FF; tick();
      quiet(1, 0); rd_addr = 7'd5; tick();
      // same-cycle read/write at addr 10
      quiet(1, 0); eng_wren = 1'b1; eng_addr = 7'd10; eng_data = 11'd3; tick();
      quiet(1, 0); eng_wren = 1'b1; eng_addr = 7'd10; eng_data = 11'd9; rd_addr = 7'd10; tick();
      quiet(1, 0); rd_addr = 7'd10; tick();
      // grant timeout: request from PLAYING with an engine write in the same cycle
      quiet(1, 0); req = 1'b1; eng_wren = 1'b1; eng_addr = 7'd99; eng_data = 11'h123; tick();
      repeat (22) begin quiet(1, 1); tick(); end
      quiet(0, 0); rd_addr = 7'd99; tick();

      // short load
      start_load(); write_words(100); finish_load();
      repeat (3) begin quiet(1, 0); tick(); end

      // resetting drops without ready
      start_load(); write_words(20);
      quiet(0, 1); resetting = 1'b0; tick();
      repeat (3) begin quiet(1, 1); tick(); end

      // asynchronous reset mid-load at load_count = 50
      start_load(); write_words(50);
      quiet(0, 0); resetting = 1'b0;
      @(negedge clk); #1;
      rst_n = 1'b0; #1;
      chk("async_nip", {31'd0, nip}, 32'd0);
      chk("async_game_active", {31'd0, game_active}, 32'd0);
      chk("async_load_error", {31'd0, load_error}, 32'd0);
      chk("async_rd_data", {21'd0, rd_data}, 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      quiet(0, 0); rd_addr = 7'd20; tick();
      quiet(0, 0); tick();

      // randomized traffic
      for (int c = 0; c < 1500; c++) begin
         quiet(1, 1);
         req   = ($urandom_range(19) == 0);
         ready = ($urandom_range(29) == 0);
         if ($urandom_range(24) == 0) resetting = ~resetting;
         tick();
      end

      quiet(0, 0); resetting = 1'b0; ready = 1'b0;
      repeat (2) tick();
      @(negedge clk); #1;
      chk("scoreboard_drained", sbq.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/object_memory_arbiter.md
# object_memory_arbiter

Owns the 128×11 object memory that holds the live board, and is the handshake partner of the new-game coordinator. Grants the coordinator the write port when it requests a new game, and counts the board words it loads. Hands the write port to the game engine once loading completes. Serves a one-cycle-latency read port to the display/logic side at all times.

## Interface
Parameters:
- ADDR_W, 7, object memory address width (depth 2^ADDR_W = 128)
- DATA_W, 11, object memory word width
- BOARD_WORDS, 104, number of board words a complete load must write (addresses 0..BOARD_WORDS-1)
- GRANT_TIMEOUT, 16, cycles allowed between grant and the coordinator raising `resetting`

Ports (clock and reset first):
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- new_game_request  in  1  one-cycle pulse from coordinator
- new_game_in_progress  out  1  grant level to coordinator
- resetting  in  1  coordinator is loading (level)
- new_game_ready  in  1  one-cycle pulse, load finished
- ngc_addr  in  ADDR_W  coordinator write address
- ngc_data  in  DATA_W  coordinator write data
- ngc_wren  in  1  coordinator write enable
- eng_addr  in  ADDR_W  engine write address
- eng_data  in  DATA_W  engine write data
- eng_wren  in  1  engine write enable
- rd_addr  in  ADDR_W  read address
- rd_data  out  DATA_W  read data, registered
- game_active  out  1  high in PLAYING; engine owns write port
- load_error  out  1  one-cycle pulse: short load or grant timeout

## Operation
- States: IDLE, GRANT, LOADING, PLAYING. Reset state is IDLE.
- IDLE: no writes accepted. `new_game_request` → GRANT.
- GRANT: `new_game_in_progress`=1; timeout counter runs from 0.
  - `resetting`=1 → LOADING; load_count cleared.
  - Counter reaches GRANT_TIMEOUT-1 with no `resetting` → IDLE, `load_error` pulse.
- LOADING: `new_game_in_progress`=1.
  - Coordinator port writes memory when `ngc_wren`=1.
  - Writes with `ngc_addr` < BOARD_WORDS increment load_count; saturates at BOARD_WORDS.
  - Writes at or above BOARD_WORDS still write memory but are not counted.
  - On `new_game_ready`: go to PLAYING. If load_count < BOARD_WORDS, also pulse `load_error` (PLAYING is entered anyway).
  - `resetting` falling without `new_game_ready` → IDLE, `load_error` pulse.
- PLAYING: `game_active`=1; engine port writes when `eng_wren`=1. `new_game_request` → GRANT; an engine write in that same cycle is still performed.
- `new_game_request` in GRANT or LOADING is ignored.
- Engine writes are dropped outside PLAYING. Coordinator writes are dropped outside LOADING.
- Exactly one write source is active per state, so writes never conflict.

## Timing
- Reset values: `new_game_in_progress`=0, `game_active`=0, `load_error`=0, `rd_data`=0. State=IDLE, counters=0.
- Memory contents are not cleared by `rst_n`.
- All outputs are registered. State outputs change on the edge after the triggering input is sampled:
  - request at edge n → `new_game_in_progress`=1 from n+1.
  - `new_game_ready` at edge m → `new_game_in_progress`=0 and `game_active`=1 from m+1.
- Write: the write is committed at the edge where the enable is sampled high in the owning state.
- Read: `rd_data` is valid at the edge after `rd_addr` is sampled (1-cycle latency).
- Read and write to the same address in the same cycle: `rd_data` returns the old word (read-before-write).
- `rst_n` asserted mid-LOADING: state goes to IDLE immediately and the grant drops. Partial board contents remain in memory.
- load_count width is ADDR_W. Timeout counter width is $clog2(GRANT_TIMEOUT).

## Structure
- Shared package holds:
  - state encoding (IDLE=0, GRANT=1, LOADING=2, PLAYING=3)
  - BOARD_WORDS, GRANT_TIMEOUT, ADDR_W, DATA_W defaults
- Sub-module `object_memory`: simple dual-port RAM, 2^ADDR_W×DATA_W.
  - Synchronous write, registered read-before-write.
  - Write port is fed by the arbiter's state-selected mux.

## Test plan
- **Full load:** request pulse; `resetting`=1 after 2 cycles; write addresses 0..104 with data = addr; `new_game_ready` pulse.
  - Expect state PLAYING, `load_error`=0.
  - Reading addr 57 returns 57; addr 104 returns 104.
- **Grant timeout:** request pulse; `resetting` never rises.
  - Expect `load_error` pulse exactly 16 cycles after grant rises, then IDLE with `new_game_in_progress`=0.
- **Short load:** write only addresses 0..99, then `new_game_ready`.
  - Expect one-cycle `load_error` and `game_active`=1.
- **Ownership:** in LOADING, `eng_wren` to addr 5 with data 0x7FF is dropped (addr 5 is unchanged). In PLAYING, the same write lands (read returns 0x7FF). In PLAYING, `ngc_wren` is ignored.
- **Same-cycle read/write:** in PLAYING, addr 10 holds 3; write 9 to addr 10 while reading addr 10.
  - Expect `rd_data`=3, then 9 on the next read.
- **Reset mid-load:** assert `rst_n`=0 at load_count=50.
  - Expect all outputs zero asynchronously and state IDLE.
  - Addr 20 still holds its loaded value after reset release.
